mem_data_arbiter: RTL and testbench

- Shares the processor's data memory (write port and read-address port) between the core and an external host. The host is a loader, debugger or DMA engine.
- Sits between the core's memory interface and mem_data.
- The core has fixed priority. Host writes are buffered in a small FIFO and drained in idle write cycles. Host reads steal idle read cycles.
- A bounded-starvation mechanism requests a one-cycle core hold.

---
 rtl/mem_data_arbiter_if.sv | 26 ++
 rtl/mem_data_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_data_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_data_arbiter_if.sv
// Host-side access channel of mem_data_arbiter: buffered write requests and
// single-outstanding read requests with a one-cycle read-data pulse.
interface mem_data_arbiter_if #(
    parameter int unsigned MDATAW = 6,
    parameter int unsigned NUBITS = 16
);
    logic              hst_wvalid;
    logic [MDATAW-1:0] hst_waddr;
    logic [NUBITS-1:0] hst_wdata;
    logic              hst_wready;
    logic              hst_rvalid;
    logic [MDATAW-1:0] hst_raddr;
    logic              hst_rready;
    logic              hst_rdvalid;
    logic [NUBITS-1:0] hst_rdata;

    modport master (
        output hst_wvalid, hst_waddr, hst_wdata, hst_rvalid, hst_raddr,
        input  hst_wready, hst_rready, hst_rdvalid, hst_rdata
    );

    modport slave (
        input  hst_wvalid, hst_waddr, hst_wdata, hst_rvalid, hst_raddr,
        output hst_wready, hst_rready, hst_rdvalid, hst_rdata
    );
endinterface

// File: rtl/mem_data_arbiter.sv
// Shares the data memory write port and read-address port between the core
// (fixed priority) and a host whose writes are FIFO-buffered and reads steal idle cycles.
module mem_data_arbiter #(
    parameter int unsigned MDATAW  = 6,
    parameter int unsigned NUBITS  = 16,
    parameter int unsigned WFDEPTH = 4,
    parameter int unsigned MAXWAIT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       core_wr,
    input  logic [MDATAW-1:0]          core_addr_w,
    input  logic [NUBITS-1:0]          core_data_w,
    input  logic                       core_rd_en,
    input  logic [MDATAW-1:0]          core_addr_r,
    output logic                       core_hold,
    mem_data_arbiter_if.slave          hst,
    output logic                       mem_wr,
    output logic [MDATAW-1:0]          mem_addr_w,
    output logic [NUBITS-1:0]          mem_din,
    output logic [MDATAW-1:0]          mem_addr_r,
    input  logic [NUBITS-1:0]          mem_dout,
    output logic [$clog2(WFDEPTH):0]   fifo_cnt
);
    localparam int unsigned AW  = $clog2(WFDEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned WCW = $clog2(MAXWAIT + 1);
    localparam logic [WCW-1:0] MAXW = WCW'(MAXWAIT);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_CAPT} rstate_e;

    logic [MDATAW-1:0] fifo_addr [WFDEPTH];
    logic [NUBITS-1:0] fifo_data [WFDEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    rstate_e           state_q, state_d;
    logic [MDATAW-1:0] raddr_q, raddr_d;
    logic [NUBITS-1:0] rdata_q, rdata_d;
    logic              rdvalid_q, rdvalid_d;
    logic              core_hold_q, core_hold_d;
    logic              empty, full, push, pop, issue;

    assign empty          = (cnt_q == '0);
    assign full           = (cnt_q == CW'(WFDEPTH));
    assign hst.hst_wready = rst && !full;
    assign hst.hst_rready = rst && (state_q == R_IDLE);
    assign push           = hst.hst_wvalid && hst.hst_wready;
    assign pop            = !core_wr && !empty;
    // A read issues only with the FIFO drained, so earlier host writes are visible.
    assign issue          = (state_q == R_WAIT) && !core_rd_en && empty;

    assign hst.hst_rdata   = rdata_q;
    assign hst.hst_rdvalid = rdvalid_q;
    assign core_hold       = core_hold_q;
    assign fifo_cnt        = cnt_q;

    always_comb begin
        mem_wr     = core_wr || !empty;
        mem_addr_w = core_wr ? core_addr_w : fifo_addr[rd_ptr_q];
        mem_din    = core_wr ? core_data_w : fifo_data[rd_ptr_q];
        mem_addr_r = issue ? raddr_q : core_addr_r;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        // Hold cycle guarantees progress, so both starvation counters restart there.
        if (core_hold_q || pop || empty) begin
            wcnt_d = '0;
        end else if (wcnt_q != MAXW) begin
            wcnt_d = wcnt_q + WCW'(1);
        end else begin
            wcnt_d = wcnt_q;
        end

        if (core_hold_q || (state_q != R_WAIT) || issue) begin
            rcnt_d = '0;
        end else if (rcnt_q != MAXW) begin
            rcnt_d = rcnt_q + WCW'(1);
        end else begin
            rcnt_d = rcnt_q;
        end

        core_hold_d = !core_hold_q && ((wcnt_q == MAXW) || (rcnt_q == MAXW));
    end

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        rdvalid_d = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (hst.hst_rvalid && hst.hst_rready) begin
                    raddr_d = hst.hst_raddr;
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (issue) begin
                    state_d = R_CAPT;
                end
            end
            R_CAPT: begin
                rdata_d   = mem_dout;
                rdvalid_d = 1'b1;
                state_d   = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= hst.hst_waddr;
            fifo_data[wr_ptr_q] <= hst.hst_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            state_q     <= R_IDLE;
            raddr_q     <= '0;
            rdata_q     <= '0;
            rdvalid_q   <= 1'b0;
            core_hold_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            rdata_q     <= rdata_d;
            rdvalid_q   <= rdvalid_d;
            core_hold_q <= core_hold_d;
        end
    end
endmodule

// File: tb/tb_mem_data_arbiter.sv
// Randomized and directed bench for mem_data_arbiter against a queue-based
// reference model of the arbitration rules, with a behavioural mem_data.
module tb_mem_data_arbiter;
    localparam int MAXW = 15;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wr, core_rd_en, core_hold, mem_wr;
    logic [5:0]  core_addr_w, core_addr_r, mem_addr_w, mem_addr_r;
    logic [15:0] core_data_w, mem_din, mem_dout;
    logic [2:0]  fifo_cnt;

    mem_data_arbiter_if #(.MDATAW(6), .NUBITS(16)) hif ();

    mem_data_arbiter #(.MDATAW(6), .NUBITS(16), .WFDEPTH(4), .MAXWAIT(15)) dut (
        .clk(clk), .rst(rst),
        .core_wr(core_wr), .core_addr_w(core_addr_w), .core_data_w(core_data_w),
        .core_rd_en(core_rd_en), .core_addr_r(core_addr_r), .core_hold(core_hold),
        .hst(hif.slave),
        .mem_wr(mem_wr), .mem_addr_w(mem_addr_w), .mem_din(mem_din),
        .mem_addr_r(mem_addr_r), .mem_dout(mem_dout), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural mem_data: registered read, read-during-write returns old data.
    logic [15:0] tbmem [64];
    always @(posedge clk) begin
        if (mem_wr) tbmem[mem_addr_w] <= mem_din;
        mem_dout <= tbmem[mem_addr_r];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scenario inputs (what the core/host would like to do this cycle)
    bit          rst_i;
    bit          c_wr, c_rd, w_v, r_v;
    logic [5:0]  c_aw, c_ar, w_a, r_a;
    logic [15:0] c_dw, w_d;

    // Reference model state
    typedef struct { logic [5:0] a; logic [15:0] d; } wr_t;
    wr_t         mq[$];
    int          m_wcnt, m_rcnt;
    bit          m_hold, m_pend, m_capt, m_rdv, m_wacc, m_racc;
    logic [5:0]  m_raddr;
    logic [15:0] m_issue_val, m_rdata;
    logic [15:0] exp_mem [64];

    task automatic model_reset();
        mq.delete();
        m_wcnt = 0; m_rcnt = 0;
        m_hold = 0; m_pend = 0; m_capt = 0; m_rdv = 0;
        m_rdata = '0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAXW) ? MAXW : v + 1;
    endfunction

    task automatic cycle();
        bit g_wr, g_rd, emp, wrdy, rrdy, e_wr, iss, push, pop, nhold;
        logic [5:0] e_aw, e_ar;
        logic [15:0] e_din;
        int nw, nr;
        @(negedge clk);
        // The core honours core_hold by idling.
        g_wr = c_wr && !m_hold;
        g_rd = c_rd && !m_hold;
        rst = rst_i;
        core_wr = g_wr; core_addr_w = c_aw; core_data_w = c_dw;
        core_rd_en = g_rd; core_addr_r = c_ar;
        hif.hst_wvalid = w_v; hif.hst_waddr = w_a; hif.hst_wdata = w_d;
        hif.hst_rvalid = r_v; hif.hst_raddr = r_a;
        if (!rst_i) model_reset();
        #1;
        emp   = (mq.size() == 0);
        wrdy  = rst_i && (mq.size() < DEPTH);
        rrdy  = rst_i && !m_pend && !m_capt;
        e_wr  = g_wr || !emp;
        e_aw  = g_wr ? c_aw : (emp ? 6'd0 : mq[0].a);
        e_din = g_wr ? c_dw : (emp ? 16'd0 : mq[0].d);
        iss   = m_pend && !g_rd && emp;
        e_ar  = iss ? m_raddr : c_ar;

        check_eq("wready", 32'(hif.hst_wready), 32'(wrdy));
        check_eq("rready", 32'(hif.hst_rready), 32'(rrdy));
        check_eq("mem_wr", 32'(mem_wr), 32'(e_wr));
        if (e_wr) begin
            check_eq("mem_addr_w", 32'(mem_addr_w), 32'(e_aw));
            check_eq("mem_din", 32'(mem_din), 32'(e_din));
        end
        check_eq("mem_addr_r", 32'(mem_addr_r), 32'(e_ar));
        check_eq("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        check_eq("core_hold", 32'(core_hold), 32'(m_hold));
        check_eq("rdvalid", 32'(hif.hst_rdvalid), 32'(m_rdv));
        check_eq("rdata", 32'(hif.hst_rdata), 32'(m_rdata));

        m_wacc = w_v && wrdy;
        m_racc = r_v && rrdy;
        if (rst_i) begin
            push  = m_wacc;
            pop   = !g_wr && !emp;
            nhold = !m_hold && (m_wcnt == MAXW || m_rcnt == MAXW);
            nw    = (m_hold || pop || emp) ? 0 : sat_inc(m_wcnt);
            nr    = (m_hold || !m_pend || iss) ? 0 : sat_inc(m_rcnt);
            if (m_capt) m_rdata = m_issue_val;
            m_rdv  = m_capt;
            m_capt = iss;
            if (iss) begin
                m_issue_val = exp_mem[m_raddr];
                m_pend = 0;
            end
            if (m_racc) begin
                m_pend = 1;
                m_raddr = r_a;
            end
            if (g_wr) exp_mem[c_aw] = c_dw;
            else if (pop) exp_mem[mq[0].a] = mq[0].d;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{a: w_a, d: w_d});
            m_hold = nhold; m_wcnt = nw; m_rcnt = nr;
        end
    endtask

    task automatic idle_inputs();
        c_wr = 0; c_rd = 0; w_v = 0; r_v = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tbmem[i] = '0;
            exp_mem[i] = '0;
        end
        rst = 1'b0;
        rst_i = 0;
        idle_inputs();
        c_aw = '0; c_ar = '0; c_dw = '0; w_a = '0; w_d = '0; r_a = '0;
        model_reset();
        repeat (3) cycle();
        rst_i = 1;
        cycle();

        // Plan 1: four host writes with an idle core
        for (int i = 1; i <= 4; i++) begin
            w_v = 1; w_a = 6'(i); w_d = 16'(i * 16'h11);
            cycle();
        end
        w_v = 0;
        repeat (3) cycle();

        // Plan 2: core writes continuously, host pushes five words
        begin
            int sent = 0;
            c_wr = 1;
            for (int t = 0; t < 30; t++) begin
                c_aw = 6'(40 + (t % 8)); c_dw = 16'($urandom);
                w_v = (sent < 5); w_a = 6'(10 + sent); w_d = 16'(16'hA000 + sent);
                cycle();
                if (m_wacc) sent++;
            end
            for (int t = 0; t < 50; t++) cycle();
            idle_inputs();
            repeat (6) cycle();
        end

        // Plan 3: write then immediately read the same address, core busy briefly
        c_wr = 1; c_aw = 6'd30; c_dw = 16'h1234;
        w_v = 1; w_a = 6'd9; w_d = 16'hBEEF;
        cycle();
        w_v = 0; r_v = 1; r_a = 6'd9;
        for (int t = 0; t < 12; t++) begin
            if (t == 4) c_wr = 0;
            cycle();
            if (m_racc) r_v = 0;
        end
        idle_inputs();
        repeat (3) cycle();

        // Plan 4: host read while the core owns the read port permanently
        c_rd = 1; r_v = 1; r_a = 6'd3;
        for (int t = 0; t < 25; t++) begin
            c_ar = 6'($urandom_range(0, 63));
            cycle();
            if (m_racc) r_v = 0;
        end
        idle_inputs();
        repeat (3) cycle();

        // Plan 5: simultaneous core write and host push with an empty FIFO
        c_wr = 1; c_aw = 6'd20; c_dw = 16'h5555;
        w_v = 1; w_a = 6'd21; w_d = 16'h6666;
        cycle();
        idle_inputs();
        repeat (3) cycle();

        // Plan 6: reset with two buffered writes and a read waiting
        c_wr = 1; c_rd = 1;
        for (int i = 0; i < 2; i++) begin
            c_aw = 6'(50 + i); c_dw = 16'($urandom);
            w_v = 1; w_a = 6'(60 + i); w_d = 16'(16'hC000 + i);
            r_v = (i == 0); r_a = 6'd61;
            cycle();
        end
        w_v = 0; r_v = 0;
        cycle();
        rst_i = 0; w_v = 1; r_v = 1;
        repeat (2) cycle();
        rst_i = 1; idle_inputs();
        repeat (5) cycle();

        // Randomized traffic with a narrow address space for collisions
        for (int t = 0; t < 1500; t++) begin
            rst_i = ($urandom_range(0, 299) != 0);
            c_wr = ($urandom_range(0, 9) < 6);
            c_rd = ($urandom_range(0, 9) < 6);
            c_aw = 6'($urandom_range(0, 7)); c_dw = 16'($urandom);
            c_ar = 6'($urandom_range(0, 7));
            w_v = ($urandom_range(0, 9) < 5);
            w_a = 6'($urandom_range(0, 7)); w_d = 16'($urandom);
            r_v = ($urandom_range(0, 9) < 4);
            r_a = 6'($urandom_range(0, 7));
            cycle();
        end
        rst_i = 1; idle_inputs();
        repeat (10) cycle();

        for (int i = 0; i < 64; i++) check_eq("mem_contents", 32'(tbmem[i]), 32'(exp_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
